// File: rtl/die_roll_engine_if.sv
// Roll-request, TRNG and result handshake bundle for die_roll_engine.
// slave = the engine, master = the requester / TRNG / result consumer side.
interface die_roll_engine_if #(
  parameter int unsigned RAND_W = 8,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned SUM_W  = 10
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [2:0]        i_die_sel;
  logic [CNT_W-1:0]  i_count;
  logic              o_stop;
  logic              i_valid;
  logic [RAND_W-1:0] i_randomData;
  logic              o_valid;
  logic              i_ready;
  logic [SUM_W-1:0]  o_sum;
  logic              o_err;

  modport slave (
    input  i_req_valid, i_die_sel, i_count, i_valid, i_randomData, i_ready,
    output o_req_ready, o_stop, o_valid, o_sum, o_err
  );

  modport master (
    output i_req_valid, i_die_sel, i_count, i_valid, i_randomData, i_ready,
    input  o_req_ready, o_stop, o_valid, o_sum, o_err
  );
endinterface

// File: rtl/die_roll_engine.sv
// Multi-die roller: one TRNG sample per die, modulo bias removed by rejection sampling.
// Optional statistics counters are enabled by defining DIE_ROLL_STATS_EN.
module die_roll_engine #(
  parameter int unsigned RAND_W   = 8,
  parameter int unsigned MAX_DICE = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned SUM_W    = 10,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic i_clk,
  input  logic i_reset_n,
  die_roll_engine_if.slave bus
`ifdef DIE_ROLL_STATS_EN
  ,
  output logic [15:0] o_reject_cnt,
  output logic [15:0] o_roll_cnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ACCUM = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int unsigned TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  // Largest multiple of the face count that fits in RAND_W bits; samples at or
  // above it are rejected so every face stays equally likely.
  function automatic logic [RAND_W:0] limit_of(input int unsigned sides);
    longint unsigned span;
    span = 64'd1 << RAND_W;
    return (RAND_W + 1)'((span / 64'(sides)) * 64'(sides));
  endfunction

  localparam logic [RAND_W:0] LIM_D4   = limit_of(4);
  localparam logic [RAND_W:0] LIM_D6   = limit_of(6);
  localparam logic [RAND_W:0] LIM_D8   = limit_of(8);
  localparam logic [RAND_W:0] LIM_D10  = limit_of(10);
  localparam logic [RAND_W:0] LIM_D12  = limit_of(12);
  localparam logic [RAND_W:0] LIM_D20  = limit_of(20);
  localparam logic [RAND_W:0] LIM_D100 = limit_of(100);

  logic [2:0]        state_q,  state_d;
  logic [2:0]        sel_q,    sel_d;
  logic [CNT_W-1:0]  rem_q,    rem_d;
  logic [RAND_W-1:0] sample_q, sample_d;
  logic [SUM_W-1:0]  sum_q,    sum_d;
  logic              err_q,    err_d;
  logic [TO_W-1:0]   to_q,     to_d;

  logic [RAND_W-1:0] mod_w;
  logic [RAND_W:0]   lim_w;
  logic [RAND_W-1:0] face_w;
  logic              reject_w;
  logic              bad_req_w;

  always_comb begin
    mod_w = '0;
    lim_w = LIM_D4;
    case (sel_q)
      3'd0: begin mod_w = sample_q % RAND_W'(4);   lim_w = LIM_D4;   end
      3'd1: begin mod_w = sample_q % RAND_W'(6);   lim_w = LIM_D6;   end
      3'd2: begin mod_w = sample_q % RAND_W'(8);   lim_w = LIM_D8;   end
      3'd3: begin mod_w = sample_q % RAND_W'(10);  lim_w = LIM_D10;  end
      3'd4: begin mod_w = sample_q % RAND_W'(12);  lim_w = LIM_D12;  end
      3'd5: begin mod_w = sample_q % RAND_W'(20);  lim_w = LIM_D20;  end
      3'd6: begin mod_w = sample_q % RAND_W'(100); lim_w = LIM_D100; end
      default: ;
    endcase
  end

  assign face_w    = mod_w + RAND_W'(1);
  assign reject_w  = {1'b0, sample_q} >= lim_w;
  assign bad_req_w = (bus.i_die_sel == 3'd7) || (bus.i_count == '0) ||
                     (32'(bus.i_count) > MAX_DICE);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rem_d    = rem_q;
    sample_d = sample_q;
    sum_d    = sum_q;
    err_d    = err_q;
    to_d     = to_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          sel_d = bus.i_die_sel;
          rem_d = bus.i_count;
          sum_d = '0;
          err_d = 1'b0;
          to_d  = '0;
          if (bad_req_w) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.i_valid) begin
          sample_d = bus.i_randomData;
          to_d     = '0;
          state_d  = S_CHECK;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          sum_d   = '0;
          state_d = S_DONE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_CHECK: begin
        state_d = reject_w ? S_REQ : S_ACCUM;
      end
      S_ACCUM: begin
        sum_d   = sum_q + SUM_W'(face_w);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        if (bus.i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      rem_q    <= '0;
      sample_q <= '0;
      sum_q    <= '0;
      err_q    <= 1'b0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rem_q    <= rem_d;
      sample_q <= sample_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  // Decoded straight from state so an async reset raises o_stop without a clock.
  assign bus.o_req_ready = (state_q == S_IDLE);
  assign bus.o_stop      = (state_q != S_REQ);
  assign bus.o_valid     = (state_q == S_DONE);
  assign bus.o_sum       = sum_q;
  assign bus.o_err       = err_q;

`ifdef DIE_ROLL_STATS_EN
  logic [15:0] reject_q;
  logic [15:0] roll_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      reject_q <= '0;
      roll_q   <= '0;
    end else begin
      if ((state_q == S_CHECK) && reject_w && (reject_q != '1))
        reject_q <= reject_q + 16'd1;
      if ((state_q == S_DONE) && bus.i_ready && !err_q && (roll_q != '1))
        roll_q <= roll_q + 16'd1;
    end
  end

  assign o_reject_cnt = reject_q;
  assign o_roll_cnt   = roll_q;
`endif

endmodule

// File: tb/tb_die_roll_engine.sv
// Randomized bench for die_roll_engine: TRNG responder, per-roll reference model
// computing the expected dice sum from the captured samples, and directed corner cases.
`timescale 1ns/1ps
module tb_die_roll_engine;
  localparam int unsigned RAND_W   = 8;
  localparam int unsigned MAX_DICE = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SUM_W    = 10;
  localparam int unsigned TIMEOUT  = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  die_roll_engine_if #(.RAND_W(RAND_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus ();

`ifdef DIE_ROLL_STATS_EN
  logic [15:0] rej_cnt, roll_cnt;
`endif

  die_roll_engine #(
    .RAND_W(RAND_W), .MAX_DICE(MAX_DICE), .CNT_W(CNT_W), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
`ifdef DIE_ROLL_STATS_EN
    ,
    .o_reject_cnt(rej_cnt),
    .o_roll_cnt(roll_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  int mode = 0;                 // TRNG responder: 0 silent, 1 random, 2 scripted
  logic [7:0] script[$];
  logic [7:0] cap_q[$];         // samples the DUT captured during the current roll

  int req_sel, req_cnt;
  bit exp_timeout   = 0;
  bit expect_result = 0;
  int exp_sum = 0;
  bit exp_err = 0;
  int rej_total  = 0;
  int roll_total = 0;

  int ncyc = 0;
  int stop_fall_cyc = 0, valid_rise_cyc = 0, stop_low_cnt = 0;
  bit stop_fell = 0, prev_stop = 1, prev_valid = 0, prev_ready = 0, prev_cap = 0;
  bit stop_after_accept = 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the captured samples, discard biased ones, sum 1-based faces.
  task automatic model_result(output int sum, output bit err);
    int tab[0:6];
    int sides, lim, got;
    logic [7:0] s;
    tab = '{4, 6, 8, 10, 12, 20, 100};
    sum = 0;
    err = 0;
    if (req_sel == 7 || req_cnt == 0 || req_cnt > int'(MAX_DICE) || exp_timeout) begin
      err = 1;
      check("err_roll_no_samples", cap_q.size(), 0);
      cap_q.delete();
      return;
    end
    sides = tab[req_sel];
    lim = ((1 << RAND_W) / sides) * sides;
    got = 0;
    while (got < req_cnt && cap_q.size() > 0) begin
      s = cap_q.pop_front();
      if (int'(s) >= lim) rej_total++;
      else begin
        sum += int'(s) % sides + 1;
        got++;
      end
    end
    check("dice_consumed", got, req_cnt);
    check("extra_samples", cap_q.size(), 0);
    cap_q.delete();
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
      prev_ready = 0;
      prev_cap   = 0;
      prev_stop  = 1;
    end else begin
      ncyc++;
      if (prev_cap) check("stop_rearm", bus.o_stop, 1);
      if (!bus.o_stop) begin
        stop_low_cnt++;
        stop_fell = 1;
        if (prev_stop) stop_fall_cyc = ncyc;
      end
      prev_stop = bus.o_stop;
      prev_cap  = !bus.o_stop && bus.i_valid;
      if (prev_cap) cap_q.push_back(bus.i_randomData);
      if (prev_valid && !prev_ready) check("valid_hold", bus.o_valid, 1);
      if (bus.o_valid && !prev_valid) begin
        valid_rise_cyc = ncyc;
        check("valid_expected", expect_result, 1);
        model_result(exp_sum, exp_err);
      end
      if (bus.o_valid) begin
        check("sum", bus.o_sum, exp_sum);
        check("err", bus.o_err, exp_err);
        if (bus.i_ready) begin
          expect_result = 0;
          if (!exp_err) roll_total++;
        end
      end
      prev_valid = bus.o_valid;
      prev_ready = bus.i_ready;
    end
  end

  // TRNG responder; garbage i_valid while o_stop is high must be ignored.
  initial begin
    bus.i_valid = 1'b0;
    bus.i_randomData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || mode == 0) bus.i_valid = 1'b0;
      else if (bus.o_stop) begin
        bus.i_valid = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
        bus.i_randomData = 8'($urandom);
      end else if (mode == 1) begin
        bus.i_valid = ($urandom_range(0, 2) != 0);
        bus.i_randomData = 8'($urandom);
      end else if (script.size() > 0) begin
        bus.i_valid = 1'b1;
        bus.i_randomData = script.pop_front();
      end else bus.i_valid = 1'b0;
    end
  end

  task automatic do_roll(input int sel, input int cnt, input int hold, input bit with_req,
                         output int dsum, output bit derr);
    int t;
    @(posedge clk);
    #1;
    t = 0;
    while (!bus.o_req_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("ready_before_req", bus.o_req_ready, 1);
    req_sel = sel;
    req_cnt = cnt;
    stop_low_cnt = 0;
    stop_fell = 0;
    expect_result = 1;
    bus.i_req_valid = 1'b1;
    bus.i_die_sel = 3'(sel);
    bus.i_count = CNT_W'(cnt);
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    stop_after_accept = bus.o_stop;
    t = 0;
    while (!bus.o_valid && t < int'(TIMEOUT) + 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("valid_within_bound", bus.o_valid, 1);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    dsum = int'(bus.o_sum);
    derr = bus.o_err;
    bus.i_ready = 1'b1;
    if (with_req) begin
      bus.i_req_valid = 1'b1;
      bus.i_die_sel = 3'd0;
      bus.i_count = CNT_W'(1);
    end
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    check("valid_drop", bus.o_valid, 0);
    check("idle_after_accept", bus.o_req_ready, 1);
  endtask

  initial begin
    int s;
    bit e;
    int sel, cnt;
    bus.i_req_valid = 1'b0;
    bus.i_die_sel = '0;
    bus.i_count = '0;
    bus.i_ready = 1'b0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_stop", bus.o_stop, 1);
    check("rst_valid", bus.o_valid, 0);
    check("rst_sum", bus.o_sum, 0);
    check("rst_err", bus.o_err, 0);
    check("rst_req_ready", bus.o_req_ready, 1);
`ifdef DIE_ROLL_STATS_EN
    check("rst_reject_cnt", rej_cnt, 0);
    check("rst_roll_cnt", roll_cnt, 0);
`endif
    rst_n = 1'b1;

    // Reset while waiting on the TRNG: immediate return to IDLE, no result.
    mode = 0;
    expect_result = 0;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b1;
    bus.i_die_sel = 3'd0;
    bus.i_count = CNT_W'(1);
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    check("midreq_stop_low", bus.o_stop, 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreq_stop_async", bus.o_stop, 1);
    check("midreq_ready_async", bus.o_req_ready, 1);
    #3;
    rst_n = 1'b1;
    cap_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check("midreq_no_valid", bus.o_valid, 0);
    check("midreq_stop_idle", bus.o_stop, 1);

    // d6 x1, sample 11 -> face 6
    mode = 2;
    script = '{8'd11};
    do_roll(1, 1, 0, 0, s, e);
    check("d6_sum", s, 6);
    check("d6_err", e, 0);
    check("d6_stop_after_accept", stop_after_accept, 0);
    check("d6_stop_low_cycles", stop_low_cnt, 1);

    // d20 x1, 250 rejected then 41 -> face 2
    script = '{8'd250, 8'd41};
    do_roll(5, 1, 0, 0, s, e);
    check("d20_sum", s, 2);
    check("d20_stop_low_cycles", stop_low_cnt, 2);

    // d100 x3, held 5 cycles, with a request racing the acceptance
    script = '{8'd199, 8'd0, 8'd99};
    do_roll(6, 3, 5, 1, s, e);
    check("d100_sum", s, 201);
    check("d100_err", e, 0);

    // Invalid requests never start the TRNG
    mode = 1;
    do_roll(7, 1, 1, 0, s, e);
    check("sel7_err", e, 1);
    check("sel7_no_stop_fall", stop_fell, 0);
    do_roll(0, 0, 0, 0, s, e);
    check("cnt0_err", e, 1);
    check("cnt0_no_stop_fall", stop_fell, 0);
    do_roll(2, 9, 0, 0, s, e);
    check("cnt9_err", e, 1);
    check("cnt9_sum", s, 0);
    check("cnt9_no_stop_fall", stop_fell, 0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      sel = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, 6)) : 7;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: cnt = 0;
          1: cnt = 9;
          default: cnt = 15;
        endcase
      end else cnt = int'($urandom_range(1, MAX_DICE));
      do_roll(sel, cnt, int'($urandom_range(0, 3)), 0, s, e);
    end

    // TRNG never answers: error exactly TIMEOUT cycles after o_stop falls
    mode = 0;
    exp_timeout = 1;
    do_roll(0, 1, 0, 0, s, e);
    exp_timeout = 0;
    check("timeout_err", e, 1);
    check("timeout_sum", s, 0);
    check("timeout_latency", valid_rise_cyc - stop_fall_cyc, TIMEOUT);

`ifdef DIE_ROLL_STATS_EN
    @(negedge clk);
    check("stats_reject_cnt", rej_cnt, rej_total);
    check("stats_roll_cnt", roll_cnt, roll_total);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end
endmodule
